seq_event_logger: RTL and testbench

Downstream consumer of the 1010 sequence detector's `flag` output. Each cycle `flag` is high is counted, timestamped with a free-running cycle counter, and pushed into a small FIFO. Software-side logic drains the FIFO through a valid/ready interface. Saturating match and drop counters plus a sticky overflow bit report totals and lost events.

---
 rtl/seq_event_logger.sv | 113 +++++++++++
 tb/tb_seq_event_logger.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_event_logger.sv
// Event logger for the sequence detector's match pulse. Each match is counted and timestamped,
// and is queued in a small FIFO that a consumer drains over a valid/ready interface.
module seq_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag,
  input  logic                     clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_ts,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic fifo_empty, fifo_full, pop, push_ok, drop;

  // EMPTY/PARTIAL/FULL are decoded from the pointers; the wrap bit separates full from empty.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && evt_ready;
    push_ok    = flag && (!fifo_full || pop);
    drop       = flag && fifo_full && !pop;
  end

  always_comb begin
    ts_d        = ts_q + 1'b1;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    match_cnt_d = match_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    if (clr) begin
      ts_d        = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      match_cnt_d = '0;
      drop_cnt_d  = '0;
      overflow_d  = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q[AW-1:0]] = ts_q;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (flag && (match_cnt_q != CNT_MAX)) begin
        match_cnt_d = match_cnt_q + 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      match_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      match_cnt_q <= match_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

  // Head is read straight from storage, so evt_valid/evt_ts never see evt_ready.
  always_comb begin
    evt_valid = !fifo_empty;
    evt_ts    = mem_q[rd_ptr_q[AW-1:0]];
    match_cnt = match_cnt_q;
    drop_cnt  = drop_cnt_q;
    overflow  = overflow_q;
    level     = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: tb/tb_seq_event_logger.sv
// Self-checking bench for seq_event_logger: table-driven vectors plus a timestamp scoreboard,
// with a second, narrow instance for the counter saturation and timestamp wrap cases.
module tb_seq_event_logger;

  localparam int DEPTH = 4;
  localparam int TS_W  = 16;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0, flag = 1'b0, clr = 1'b0, evt_ready = 1'b0;
  logic             evt_valid, overflow;
  logic [TS_W-1:0]  evt_ts;
  logic [CNT_W-1:0] match_cnt, drop_cnt;
  logic [LW-1:0]    level;

  logic       rst_s = 1'b0, flag_s = 1'b0, clr_s = 1'b0, ready_s = 1'b0;
  logic       valid_s, ovf_s;
  logic [3:0] ts_s;
  logic [2:0] match_s, drop_s;
  logic [2:0] level_s;

  seq_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flag(flag), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts),
    .match_cnt(match_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .level(level)
  );

  seq_event_logger #(.DEPTH(4), .TS_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst_s), .flag(flag_s), .clr(clr_s),
    .evt_valid(valid_s), .evt_ready(ready_s), .evt_ts(ts_s),
    .match_cnt(match_s), .drop_cnt(drop_s), .overflow(ovf_s), .level(level_s)
  );

  int total = 0;
  int bad   = 0;

  logic [TS_W-1:0] sb [$];
  logic [TS_W-1:0] m_ts;
  int              m_match, m_drop;
  logic            m_ovf;

  typedef struct {
    logic f;
    logic r;
    logic c;
    int   lvl;
    int   mat;
    int   drp;
    logic ovf;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic f, input logic r, input logic c,
                              input int lvl, input int mat, input int drp, input logic ovf);
    vec_t v;
    v.f = f; v.r = r; v.c = c; v.lvl = lvl; v.mat = mat; v.drp = drp; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_ts    = '0;
    m_match = 0;
    m_drop  = 0;
    m_ovf   = 1'b0;
  endtask

  // Drive one cycle: pre-edge checks, model update, edge, post-edge checks.
  task automatic cycle(input logic f, input logic r, input logic c);
    logic            do_pop;
    logic [TS_W-1:0] head;
    flag = f; evt_ready = r; clr = c;
    #1;
    chk("valid_pre", evt_valid, sb.size() != 0);
    do_pop = (sb.size() != 0) && r;
    if (c) begin
      model_clear();
    end else begin
      if (do_pop) begin
        head = sb.pop_front();
        chk("pop_ts", evt_ts, head);
      end
      if (f) begin
        if (m_match < 255) m_match++;
        if (sb.size() == DEPTH) begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1'b1;
        end else begin
          sb.push_back(m_ts);
        end
      end
      m_ts = m_ts + 1'b1;
    end
    @(posedge clk);
    #1;
    flag = 1'b0; evt_ready = 1'b0; clr = 1'b0;
    chk("level", level, sb.size());
    chk("match_cnt", match_cnt, m_match);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", overflow, m_ovf);
    chk("valid_post", evt_valid, sb.size() != 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; flag = 1'b0; evt_ready = 1'b0; clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);
    #4;
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    int pulses;

    // Overflow scenario: flags at ts=2,4,...,12 with the consumer stalled, then a drain.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 2, 2, 0, 0);
    tbl[5]  = mk(0, 0, 0, 2, 2, 0, 0);
    tbl[6]  = mk(1, 0, 0, 3, 3, 0, 0);
    tbl[7]  = mk(0, 0, 0, 3, 3, 0, 0);
    tbl[8]  = mk(1, 0, 0, 4, 4, 0, 0);
    tbl[9]  = mk(0, 0, 0, 4, 4, 0, 0);
    tbl[10] = mk(1, 0, 0, 4, 5, 1, 1);
    tbl[11] = mk(0, 0, 0, 4, 5, 1, 1);
    tbl[12] = mk(1, 0, 0, 4, 6, 2, 1);
    tbl[13] = mk(0, 1, 0, 3, 6, 2, 1);
    tbl[14] = mk(0, 1, 0, 2, 6, 2, 1);
    tbl[15] = mk(0, 1, 0, 1, 6, 2, 1);
    tbl[16] = mk(0, 1, 0, 0, 6, 2, 1);

    // Basic event at ts=5
    do_reset();
    chk("rst_ts", evt_ts, 0);
    repeat (5) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("basic_valid", evt_valid, 1);
    chk("basic_ts", evt_ts, 5);
    chk("basic_match", match_cnt, 1);
    chk("basic_level", level, 1);
    cycle(0, 1, 0);
    chk("basic_pop_valid", evt_valid, 0);
    chk("basic_pop_level", level, 0);

    // Table-driven overflow and drain
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].f, tbl[i].r, tbl[i].c);
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_match", match_cnt, tbl[i].mat);
      chk("tbl_drop", drop_cnt, tbl[i].drp);
      chk("tbl_ovf", overflow, tbl[i].ovf);
    end

    // Full with simultaneous push and pop
    repeat (4) cycle(1, 0, 0);
    chk("full_level", level, 4);
    cycle(1, 1, 0);
    chk("fullpp_drop", drop_cnt, 2);
    chk("fullpp_level", level, 4);
    repeat (4) cycle(0, 1, 0);
    chk("fullpp_drained", level, 0);

    // clr colliding with flag while three entries are queued and overflow is set
    repeat (3) cycle(1, 0, 0);
    chk("pre_clr_level", level, 3);
    chk("pre_clr_ovf", overflow, 1);
    cycle(1, 0, 1);
    chk("clr_level", level, 0);
    chk("clr_match", match_cnt, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_valid", evt_valid, 0);

    // Asynchronous reset between edges with two entries queued
    repeat (2) cycle(1, 0, 0);
    chk("pre_arst_level", level, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_match", match_cnt, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_ovf", overflow, 0);
    #1;
    rst = 1'b1;
    model_clear();
    cycle(1, 0, 0);
    chk("arst_first_ts", evt_ts, 0);
    cycle(0, 1, 0);

    // Narrow instance: 3-bit counters saturate, 4-bit timestamp wraps
    ready_s = 1'b1;
    #2;
    rst_s = 1'b1;
    pulses = 0;
    for (int c = 0; c < 18; c++) begin
      flag_s = c[0];
      @(posedge clk);
      #1;
      if (c[0]) begin
        pulses++;
        chk("sat_valid", valid_s, 1);
        chk("sat_ts", ts_s, c % 16);
        chk("sat_match", match_s, (pulses > 7) ? 7 : pulses);
      end
      flag_s = 1'b0;
    end
    chk("sat_match_final", match_s, 7);
    chk("sat_last_ts", ts_s, 1);
    chk("sat_drop", drop_s, 0);
    chk("sat_ovf", ovf_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
